key_input_conditioner: RTL and testbench

Front-end conditioner for the seven piano keys, placed directly upstream of the piano controller's `keys` input. It synchronises and debounces the raw switch levels and encodes the lowest pressed key as a note code. It also emits single-cycle press and release events and measures how long the current note has been held in millisecond ticks. The piano controller and any recorder consume `keys_clean`, `note` and the event pulses instead of raw pins.

---
 rtl/key_input_conditioner.sv | 98 +++++++++
 tb/tb_key_input_conditioner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Seven-key front end: synchronise, debounce, priority-encode the lowest pressed key,
// emit press/release events and time how long the current note has been held.
module key_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned TICK_CYCLES     = 100_000,
  parameter int unsigned HOLD_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        keys_raw,
  output logic [6:0]        keys_clean,
  output logic [3:0]        note,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [HOLD_W-1:0] hold_ms
);

  localparam int unsigned NUM_KEYS = 7;
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PRE_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  logic [6:0]       s1;
  logic [6:0]       s2;
  logic [CNT_W-1:0] db_cnt [NUM_KEYS];
  logic [PRE_W-1:0] prescale;
  logic [3:0]       note_nx;
  logic             press_c;
  logic             release_c;

  // Two-flop synchroniser and per-key debounce; keys_clean holds the accepted levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      keys_clean <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= keys_raw;
      s2 <= s1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (s2[i] == keys_clean[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          keys_clean[i] <= s2[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest pressed key wins; scanning downward leaves the lowest index last.
  always_comb begin
    note_nx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_clean[i]) note_nx = 4'(i + 1);
    end
  end

  assign press_c   = (note_nx != 4'd0) && (note_nx != note);
  assign release_c = (note_nx == 4'd0) && (note != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note          <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      note          <= note_nx;
      press_pulse   <= press_c;
      release_pulse <= release_c;
    end
  end

  // Hold timer restarts on every new note and freezes while no key is down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      hold_ms  <= '0;
    end else if (press_c) begin
      prescale <= '0;
      hold_ms  <= '0;
    end else if (note != 4'd0) begin
      if (prescale == PRE_LAST) begin
        prescale <= '0;
        if (hold_ms != '1) hold_ms <= hold_ms + HOLD_W'(1);
      end else begin
        prescale <= prescale + PRE_W'(1);
      end
    end else begin
      prescale <= '0;
    end
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed scenarios plus random key activity,
// compared every cycle against a window-based behavioural model.
module tb_key_input_conditioner;

  localparam int unsigned D    = 4;
  localparam int unsigned T    = 10;
  localparam int unsigned HW   = 4;
  localparam int unsigned HMAX = (1 << HW) - 1;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [6:0]    keys_raw = 7'd0;
  logic [6:0]    keys_clean;
  logic [3:0]    note;
  logic          press_pulse;
  logic          release_pulse;
  logic [HW-1:0] hold_ms;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_input_conditioner #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T), .HOLD_W(HW)) dut (
    .clk(clk), .reset(reset), .keys_raw(keys_raw), .keys_clean(keys_clean),
    .note(note), .press_pulse(press_pulse), .release_pulse(release_pulse), .hold_ms(hold_ms)
  );

  // Model: a key's accepted level flips once the last D synchronised samples all disagree with it.
  logic [6:0]    hist [D+1];
  logic [6:0]    m_clean, m_clean_nx, diff_all;
  logic [3:0]    m_note, m_enc;
  logic          m_press, m_rel;
  int            m_held;
  logic [HW-1:0] m_hold;

  function automatic logic [3:0] lowest(input logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  always_comb begin
    diff_all = 7'h7F;
    for (int j = 1; j <= D; j++) diff_all = diff_all & (hist[j] ^ m_clean);
    m_clean_nx = m_clean ^ diff_all;
  end

  assign m_enc  = lowest(m_clean);
  assign m_hold = (m_held / T >= HMAX) ? HW'(HMAX) : HW'(m_held / T);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j <= D; j++) hist[j] <= 7'd0;
      m_clean <= 7'd0;
      m_note  <= 4'd0;
      m_press <= 1'b0;
      m_rel   <= 1'b0;
      m_held  <= 0;
    end else begin
      hist[0] <= keys_raw;
      for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
      m_clean <= m_clean_nx;
      m_note  <= m_enc;
      m_press <= (m_enc != 4'd0) && (m_enc != m_note);
      m_rel   <= (m_enc == 4'd0) && (m_note != 4'd0);
      if ((m_enc != 4'd0) && (m_enc != m_note)) m_held <= 0;
      else if (m_note != 4'd0) m_held <= m_held + 1;
    end
  end

  task automatic test_reset();
    logic [16:0] got;
    int presses;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    keys_raw = 7'h7F;
    repeat (40) @(negedge clk);
    keys_raw = 7'h00;
    repeat (2) @(negedge clk);
    keys_raw = 7'h7F;
    if ({note, hold_ms} !== {4'd1, HW'(3)}) begin
      bad++; $display("FAIL reset_pre got=%h exp=%h", {note, hold_ms}, {4'd1, HW'(3)});
    end
    total++;
    #2 reset = 1'b0;
    #1 got = {keys_clean, note, press_pulse, release_pulse, hold_ms};
    if (got !== 17'd0) begin
      bad++; $display("FAIL reset_values got=%h exp=0", got);
    end
    total++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    presses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({keys_clean, note, press_pulse, release_pulse, hold_ms} !== {m_clean, m_note, m_press, m_rel, m_hold}) begin
        bad++; $display("FAIL reset_model k=%0d got=%h exp=%h", k,
          {keys_clean, note, press_pulse, release_pulse, hold_ms}, {m_clean, m_note, m_press, m_rel, m_hold});
      end
      total++;
      if (press_pulse) presses++;
      if (k == 6) begin
        if ({note, press_pulse} !== {4'd1, 1'b1}) begin
          bad++; $display("FAIL reset_rearm_press got=%h exp=%h", {note, press_pulse}, {4'd1, 1'b1});
        end
        total++;
      end
    end
    if (presses != 1) begin
      bad++; $display("FAIL reset_press_count got=%0d exp=1", presses);
    end
    total++;
    keys_raw = 7'h00;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int presses, releases;
    logic [HW-1:0] hold_rel;
    presses = 0; releases = 0; hold_rel = '0;
    keys_raw = 7'b0000100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ({keys_clean, note, press_pulse, release_pulse, hold_ms} !== {m_clean, m_note, m_press, m_rel, m_hold}) begin
        bad++; $display("FAIL press_model k=%0d got=%h exp=%h", k,
          {keys_clean, note, press_pulse, release_pulse, hold_ms}, {m_clean, m_note, m_press, m_rel, m_hold});
      end
      total++;
      if (press_pulse) presses++;
      if (k == 4 && keys_clean !== 7'd0) begin
        bad++; $display("FAIL press_early got=%b exp=0", keys_clean);
      end
      if (k == 5 && {keys_clean, note} !== {7'b0000100, 4'd0}) begin
        bad++; $display("FAIL press_clean got=%h exp=%h", {keys_clean, note}, {7'b0000100, 4'd0});
      end
      if (k == 6 && {note, press_pulse} !== {4'd3, 1'b1}) begin
        bad++; $display("FAIL press_note got=%h exp=%h", {note, press_pulse}, {4'd3, 1'b1});
      end
      if (k == 4 || k == 5 || k == 6) total++;
    end
    if (presses != 1) begin
      bad++; $display("FAIL press_count got=%0d exp=1", presses);
    end
    total++;
    keys_raw = 7'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (release_pulse) releases++;
      if (k == 6) begin
        hold_rel = hold_ms;
        if ({note, release_pulse, hold_ms} !== {4'd0, 1'b1, HW'(1)}) begin
          bad++; $display("FAIL release_edge got=%h exp=%h", {note, release_pulse, hold_ms}, {4'd0, 1'b1, HW'(1)});
        end
        total++;
      end
    end
    if (releases != 1) begin
      bad++; $display("FAIL release_count got=%0d exp=1", releases);
    end
    total++;
    repeat (15) @(negedge clk);
    if (hold_ms !== hold_rel) begin
      bad++; $display("FAIL release_frozen got=%0d exp=%0d", hold_ms, hold_rel);
    end
    total++;
  endtask

  task automatic test_bounce();
    logic pat [12] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
    int presses;
    for (int k = 0; k < 12 + D + 2; k++) begin
      keys_raw = (k < 12) ? {6'd0, pat[k]} : 7'd0;
      @(negedge clk);
      if ({keys_clean, note, press_pulse, release_pulse} !== 13'd0) begin
        bad++; $display("FAIL bounce_reject k=%0d got=%h exp=0", k, {keys_clean, note, press_pulse, release_pulse});
      end
      total++;
    end
    presses = 0;
    keys_raw = 7'd1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (press_pulse) presses++;
    end
    if ({presses[3:0], note} !== {4'd1, 4'd1}) begin
      bad++; $display("FAIL bounce_accept got=%h exp=%h", {presses[3:0], note}, {4'd1, 4'd1});
    end
    total++;
    keys_raw = 7'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_priority();
    int p, r;
    logic [6:0] step_raw [4] = '{7'b0010000, 7'b0010010, 7'b0010000, 7'b1010000};
    logic [3:0] step_note [4] = '{4'd5, 4'd2, 4'd5, 4'd5};
    int step_p [4] = '{1, 1, 1, 0};
    for (int s = 0; s < 4; s++) begin
      keys_raw = step_raw[s];
      p = 0; r = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (press_pulse) p++;
        if (release_pulse) r++;
        if ({keys_clean, note, press_pulse, release_pulse, hold_ms} !== {m_clean, m_note, m_press, m_rel, m_hold}) begin
          bad++; $display("FAIL prio_model s=%0d k=%0d got=%h exp=%h", s, k,
            {keys_clean, note, press_pulse, release_pulse, hold_ms}, {m_clean, m_note, m_press, m_rel, m_hold});
        end
        total++;
      end
      if (note !== step_note[s] || keys_clean !== step_raw[s] || p != step_p[s] || r != 0) begin
        bad++; $display("FAIL prio_step s=%0d got note=%0d clean=%b p=%0d r=%0d exp note=%0d clean=%b p=%0d r=0",
          s, note, keys_clean, p, r, step_note[s], step_raw[s], step_p[s]);
      end
      total++;
    end
    keys_raw = 7'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_hold();
    int waited;
    logic [HW-1:0] exp_h;
    for (int pass = 0; pass < 2; pass++) begin
      keys_raw = 7'd1;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!press_pulse && waited < 20);
      if (!press_pulse || hold_ms !== HW'(0)) begin
        bad++; $display("FAIL hold_start pass=%0d got pulse=%b hold=%0d exp pulse=1 hold=0", pass, press_pulse, hold_ms);
      end
      total++;
      if (pass == 1) break;
      for (int t = 1; t <= 200; t++) begin
        @(negedge clk);
        exp_h = (t / 10 >= 15) ? HW'(15) : HW'(t / 10);
        if (hold_ms !== exp_h) begin
          bad++; $display("FAIL hold_step t=%0d got=%0d exp=%0d", t, hold_ms, exp_h);
        end
        total++;
      end
      keys_raw = 7'd0;
      repeat (20) @(negedge clk);
      if ({note, hold_ms} !== {4'd0, HW'(15)}) begin
        bad++; $display("FAIL hold_after_release got=%h exp=%h", {note, hold_ms}, {4'd0, HW'(15)});
      end
      total++;
    end
    keys_raw = 7'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int k = 0; k < 1500; k++) begin
      if (left == 0) begin
        case ($urandom_range(0, 3))
          0: keys_raw = 7'($urandom);
          1: keys_raw = keys_raw ^ 7'(1 << $urandom_range(0, 6));
          2: keys_raw = 7'd0;
          default: keys_raw = 7'(1 << $urandom_range(0, 6));
        endcase
        left = $urandom_range(1, 3 * D);
      end
      left--;
      @(negedge clk);
      if ({keys_clean, note, press_pulse, release_pulse, hold_ms} !== {m_clean, m_note, m_press, m_rel, m_hold}) begin
        bad++; $display("FAIL random_model k=%0d got=%h exp=%h", k,
          {keys_clean, note, press_pulse, release_pulse, hold_ms}, {m_clean, m_note, m_press, m_rel, m_hold});
      end
      total++;
      if (press_pulse && release_pulse) begin
        bad++; $display("FAIL random_exclusive k=%0d got=11 exp=not both", k);
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
